// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial signed subtractor.
//   state_t        : FSM encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : operand width used when the top is not overridden
//   cnt_width()    : bits needed for a counter spanning 0..w
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // The bit counter must reach WIDTH, i.e. hold WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: computes a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/signed_serial_subtractor.sv
// Bit-serial signed subtractor: DIFF = A - B computed LSB first, one bit
// per clock over WIDTH+1 cycles, with valid/ready handshakes on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (A minuend, B subtrahend)
//   out_valid/out_ready : result handshake
//   DIFF                : exact WIDTH+1 bit signed difference
//   overflow            : difference does not fit in WIDTH signed bits
//   SAT_DIFF            : WIDTH-bit saturated difference, present only when
//                         the SERIAL_SUB_SAT_EN macro is defined
module signed_serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   DIFF,
    output logic                    overflow
`ifdef SERIAL_SUB_SAT_EN
    ,
    output logic signed [WIDTH-1:0] SAT_DIFF
`endif
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH:0]  a_q;
    logic [WIDTH:0]  b_q;
    logic            borrow_q;
    // Holds the WIDTH most recently produced difference bits; the newest
    // bit sits at the MSB so the final bit completes the word in place.
    logic [WIDTH-1:0] sh_q;

    logic            in_ready_q;
    logic            out_valid_q;
    logic [WIDTH:0]  diff_q;
    logic            ovf_q;

    logic            cell_d;
    logic            cell_bout;
    logic [WIDTH:0]  diff_d;
    logic            ovf_d;

    // Operands shift right each RUN cycle, so bit 0 is always the current bit.
    sub_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        diff_d = {cell_d, sh_q};
        ovf_d  = diff_d[WIDTH] ^ diff_d[WIDTH-1];
    end

`ifdef SERIAL_SUB_SAT_EN
    logic [WIDTH-1:0] sat_q;
    logic [WIDTH-1:0] sat_d;

    always_comb begin
        sat_d = diff_d[WIDTH-1:0];
        if (ovf_d) begin
            // Sign of the exact result picks the clamp direction.
            sat_d = diff_d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    assign SAT_DIFF = sat_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            sh_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            ovf_q       <= 1'b0;
`ifdef SERIAL_SUB_SAT_EN
            sat_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= {A[WIDTH-1], A};
                        b_q        <= {B[WIDTH-1], B};
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end

                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= cell_bout;
                    sh_q     <= diff_d[WIDTH:1];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Final borrow is dropped: WIDTH+1 bits already hold
                        // the exact difference.
                        diff_q      <= diff_d;
                        ovf_q       <= ovf_d;
`ifdef SERIAL_SUB_SAT_EN
                        sat_q       <= sat_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign DIFF      = diff_q;
    assign overflow  = ovf_q;

endmodule
